// File: rtl/flash_cmd_sequencer.sv
// rtl/flash_cmd_sequencer.sv - P30 flash command sequencer for the memory controller flash port
// Turns host read/program/erase/unlock requests into single-req bus accesses with status polling.
module flash_cmd_sequencer #(
  parameter logic [23:0] POLL_MAX = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [22:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic [7:0]  status,
  output logic        err,
  output logic        timeout,
  output logic [22:0] mem_address,
  output logic [15:0] mem_to_mem,
  input  logic [15:0] mem_from_mem,
  output logic        mem_req,
  output logic        mem_wren,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_CMD2, S_POLL, S_CLR, S_ARRAY, S_READ, S_DONE
  } state_t;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_PROGRAM = 2'd1;
  localparam logic [1:0] OP_ERASE   = 2'd2;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_op;
  logic [22:0] r_addr, r_mem_address;
  logic [15:0] r_wdata, r_mem_to_mem, r_rdata;
  logic [7:0]  r_status;
  logic [23:0] r_poll_cnt;
  logic        r_array_mode, r_busy, r_cmd_ready, r_mem_req, r_mem_wren, r_err, r_timeout;
  logic        w_accept, w_complete, w_issue, w_wr, w_err_hit;
  logic [15:0] w_wdata;
  logic [23:0] w_poll_inc;

  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_complete = r_busy & mem_ready;
  assign w_err_hit  = |(mem_from_mem[7:0] & 8'h3A);
  assign w_poll_inc = r_poll_cnt + 24'd1;

  // r_busy marks an access in flight; a state issues exactly once while it is clear.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_wr        = 1'b0;
    w_wdata     = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_READ) w_state_nxt = r_array_mode ? S_READ : S_ARRAY;
          else                   w_state_nxt = S_CMD1;
        end
      end
      S_CMD1: begin
        w_issue = !r_busy;
        w_wr    = 1'b1;
        case (r_op)
          OP_PROGRAM: w_wdata = 16'h0040;
          OP_ERASE:   w_wdata = 16'h0020;
          default:    w_wdata = 16'h0060;
        endcase
        if (w_complete) w_state_nxt = S_CMD2;
      end
      S_CMD2: begin
        w_issue = !r_busy;
        w_wr    = 1'b1;
        w_wdata = (r_op == OP_PROGRAM) ? r_wdata : 16'h00D0;
        if (w_complete) w_state_nxt = S_POLL;
      end
      S_POLL: begin
        w_issue = !r_busy;
        if (w_complete) begin
          if (mem_from_mem[7])              w_state_nxt = w_err_hit ? S_CLR : S_ARRAY;
          else if (w_poll_inc == POLL_MAX)  w_state_nxt = S_CLR;
        end
      end
      S_CLR: begin
        w_issue = !r_busy;
        w_wr    = 1'b1;
        w_wdata = 16'h0050;
        if (w_complete) w_state_nxt = S_ARRAY;
      end
      S_ARRAY: begin
        w_issue = !r_busy;
        w_wr    = 1'b1;
        w_wdata = 16'h00FF;
        if (w_complete) w_state_nxt = (r_op == OP_READ) ? S_READ : S_DONE;
      end
      S_READ: begin
        w_issue = !r_busy;
        if (w_complete) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_READ;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_array_mode  <= 1'b0;
      r_busy        <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_mem_address <= '0;
      r_mem_to_mem  <= '0;
      r_rdata       <= '0;
      r_status      <= '0;
      r_err         <= 1'b0;
      r_timeout     <= 1'b0;
      r_poll_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_mem_req   <= w_issue;
      if (w_issue) begin
        r_busy        <= 1'b1;
        r_mem_address <= r_addr;
        r_mem_to_mem  <= w_wdata;
        r_mem_wren    <= w_wr;
      end
      if (w_complete) r_busy <= 1'b0;
      if (w_accept) begin
        r_op      <= cmd_op;
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_err     <= 1'b0;
        r_timeout <= 1'b0;
        if (cmd_op != OP_READ) r_status <= 8'h00;
      end
      if (r_state == S_CMD1) r_array_mode <= 1'b0;
      if (w_complete) begin
        case (r_state)
          S_CMD2:  r_poll_cnt <= '0;
          S_POLL: begin
            r_status   <= mem_from_mem[7:0];
            r_poll_cnt <= w_poll_inc;
            if (mem_from_mem[7])             r_err     <= w_err_hit;
            else if (w_poll_inc == POLL_MAX) r_timeout <= 1'b1;
          end
          S_ARRAY: r_array_mode <= 1'b1;
          S_READ:  r_rdata      <= mem_from_mem;
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign done        = (r_state == S_DONE);
  assign rdata       = r_rdata;
  assign status      = r_status;
  assign err         = r_err;
  assign timeout     = r_timeout;
  assign mem_address = r_mem_address;
  assign mem_to_mem  = r_mem_to_mem;
  assign mem_req     = r_mem_req;
  assign mem_wren    = r_mem_wren;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb/tb_flash_cmd_sequencer.sv - randomized bench for flash_cmd_sequencer against an operation-level model
// The memory model answers each req after a random delay; expected access lists come from the op rules.
module tb_flash_cmd_sequencer;

  localparam int POLLS = 8;
  localparam logic [1:0] OP_READ = 2'd0, OP_PROGRAM = 2'd1, OP_ERASE = 2'd2, OP_UNLOCK = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [22:0] addr;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [22:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        done;
  logic [15:0] rdata;
  logic [7:0]  status;
  logic        err;
  logic        timeout;
  logic [22:0] mem_address;
  logic [15:0] mem_to_mem;
  logic [15:0] mem_from_mem = 16'h0000;
  logic        mem_req;
  logic        mem_wren;
  logic        mem_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_ready_cyc = 0;

  logic [15:0] rd_q[$];
  acc_t        log_q[$];
  acc_t        exp_q[$];

  logic        m_array;
  logic [7:0]  m_status;
  logic [15:0] m_rdata;

  flash_cmd_sequencer #(.POLL_MAX(24'(POLLS))) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .done(done), .rdata(rdata), .status(status), .err(err), .timeout(timeout),
    .mem_address(mem_address), .mem_to_mem(mem_to_mem), .mem_from_mem(mem_from_mem),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Controller model: one access per rising req, completion pulse after 1..4 negedges.
  acc_t cur;
  logic pending = 1'b0;
  logic stable  = 1'b1;
  logic prev_req = 1'b0;
  int   lat = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (mem_req && !prev_req) check("req_idle", 32'(pending), 32'd0);
      if (prev_req) check("req_width", 32'(mem_req), 32'd0);
      if (pending) begin
        if (mem_address != cur.addr || mem_wren != cur.wr || (cur.wr && mem_to_mem != cur.data))
          stable = 1'b0;
        if (lat == 0) begin
          if (!cur.wr) begin
            if (rd_q.size() > 0) mem_from_mem = rd_q.pop_front();
            else                 mem_from_mem = 16'h0000;
            cur.data = mem_from_mem;
          end
          mem_ready = 1'b1;
          pending   = 1'b0;
          check("acc_stable", 32'(stable), 32'd1);
          log_q.push_back(cur);
          last_ready_cyc = cyc;
        end else begin
          lat--;
        end
      end
      if (mem_req && !prev_req) begin
        cur     = {mem_wren, mem_address, mem_to_mem};
        pending = 1'b1;
        stable  = 1'b1;
        lat     = int'($urandom_range(0, 3));
      end
    end
    prev_req = mem_req;
  end

  task automatic check_reset_vals();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_to_mem", 32'(mem_to_mem), 32'd0);
  endtask

  // Expected bus trace and results derived from the operation rules and the queued read data.
  task automatic build_expected(input logic [1:0] op, input logic [22:0] addr, input logic [15:0] wdata,
                                output logic e_err, output logic e_to);
    logic [15:0] s16;
    logic [15:0] code;
    int          poll_i;
    logic        fin;
    exp_q.delete();
    e_err = 1'b0;
    e_to  = 1'b0;
    if (op == OP_READ) begin
      if (!m_array) exp_q.push_back({1'b1, addr, 16'h00FF});
      s16 = (rd_q.size() > 0) ? rd_q[0] : 16'h0000;
      exp_q.push_back({1'b0, addr, s16});
      m_rdata = s16;
      m_array = 1'b1;
    end else begin
      code = (op == OP_PROGRAM) ? 16'h0040 : (op == OP_ERASE) ? 16'h0020 : 16'h0060;
      exp_q.push_back({1'b1, addr, code});
      exp_q.push_back({1'b1, addr, (op == OP_PROGRAM) ? wdata : 16'h00D0});
      poll_i = 0;
      fin    = 1'b0;
      while (!fin) begin
        s16 = (poll_i < rd_q.size()) ? rd_q[poll_i] : 16'h0000;
        exp_q.push_back({1'b0, addr, s16});
        poll_i++;
        m_status = s16[7:0];
        if (s16[7]) begin
          e_err = ((s16[7:0] & 8'h3A) != 8'h00);
          fin   = 1'b1;
        end else if (poll_i == POLLS) begin
          e_to = 1'b1;
          fin  = 1'b1;
        end
      end
      if (e_err || e_to) exp_q.push_back({1'b1, addr, 16'h0050});
      exp_q.push_back({1'b1, addr, 16'h00FF});
      m_array = 1'b1;
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [22:0] addr, input logic [15:0] wdata);
    int k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ready_drop", 32'(cmd_ready), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [22:0] addr, input logic [15:0] wdata);
    logic e_err, e_to;
    int   k = 0;
    int   n;
    build_expected(op, addr, wdata, e_err, e_to);
    log_q.delete();
    issue_cmd(op, addr, wdata);
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_latency", 32'(cyc - last_ready_cyc), 32'd1);
    check("ready_at_done", 32'(cmd_ready), 32'd0);
    check("rdata", 32'(rdata), 32'(m_rdata));
    check("status", 32'(status), 32'(m_status));
    check("err", 32'(err), 32'(e_err));
    check("timeout", 32'(timeout), 32'(e_to));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("ready_back", 32'(cmd_ready), 32'd1);
    check("n_access", 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("acc_wr", 32'(log_q[i].wr), 32'(exp_q[i].wr));
      check("acc_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
      check("acc_data", 32'(log_q[i].data), 32'(exp_q[i].data));
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [7:0]  fin_s;
    int          nready;
    int          k;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    m_array   = 1'b0;
    m_status  = 8'h00;
    m_rdata   = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    rd_q = '{16'hBEEF};
    run_op(OP_READ, 23'h000010, 16'h0000);
    rd_q = '{16'h5A5A};
    run_op(OP_READ, 23'h000011, 16'h0000);
    rd_q = '{16'h0000, 16'h0000, 16'h0000, 16'h0080};
    run_op(OP_PROGRAM, 23'h001000, 16'h1234);
    rd_q = '{16'h00A0};
    run_op(OP_ERASE, 23'h020000, 16'h0000);
    rd_q.delete();
    repeat (12) rd_q.push_back(16'h0000);
    run_op(OP_UNLOCK, 23'h030000, 16'h0000);

    for (int t = 0; t < 24; t++) begin
      op = 2'($urandom_range(0, 3));
      rd_q.delete();
      if (op == OP_READ) begin
        rd_q.push_back(16'($urandom));
      end else begin
        nready = int'($urandom_range(0, 10));
        for (int i = 0; i < nready; i++) rd_q.push_back({8'($urandom), 8'($urandom) & 8'h7F});
        fin_s = ($urandom_range(0, 1) == 1) ? (8'h80 | (8'($urandom) & 8'h3A)) : (8'h80 | (8'($urandom) & 8'h45));
        rd_q.push_back({8'($urandom), fin_s});
      end
      run_op(op, 23'($urandom), 16'($urandom));
    end

    rd_q.delete();
    repeat (20) rd_q.push_back(16'h0000);
    log_q.delete();
    issue_cmd(OP_ERASE, 23'h040000, 16'h0000);
    k = 0;
    while (log_q.size() < 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("poll_reached", 32'(log_q.size() >= 3), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    repeat (3) begin
      @(negedge clk);
      check("req_in_reset", 32'(mem_req), 32'd0);
    end
    rst_n    = 1'b1;
    m_array  = 1'b0;
    m_status = 8'h00;
    m_rdata  = 16'h0000;
    @(negedge clk);
    check("ready_after_rst2", 32'(cmd_ready), 32'd1);
    rd_q = '{16'hC0DE};
    run_op(OP_READ, 23'h000007, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
